match_ctrl: RTL and testbench
=============================

Name: match_ctrl

Overview:
- Match-level sequencer for the pong animation datapath: decides when the ball is served, when the playfield is held in reset, and when a match is won.
- Consumes the one-cycle score pulses from the animation block and keeps per-player scores.
- Drives the animation block's active-high reset and its serve (stop_ball) input.
- Exports scores, countdown value and winner for the seven-segment/scoreboard logic.

Parameters:
- TICK_CYCLES, 100000000, clk cycles per countdown step (1 s at 100 MHz); legal range 2..2^32-1
- SERVE_DELAY, 3, countdown steps before each serve; legal range 1..15
- WIN_SCORE, 7, score that ends the match; legal range 1..15

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start_btn  in  1  raw start button, asynchronous to clk, already debounced
- score1  in  1  one-cycle pulse, player 1 scored
- score2  in  1  one-cycle pulse, player 2 scored
- anim_reset  out  1  active-high reset to the animation block
- serve  out  1  one-cycle serve pulse, wired to stop_ball
- p1_score  out  4  player 1 score
- p2_score  out  4  player 2 score
- countdown  out  4  remaining countdown steps; 0 outside COUNTDOWN
- game_over  out  1  high while in GAME_OVER
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over=1
- state_o  out  3  current state encoding, for debug and LEDs

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on port reset.
- Reset (reset=0), applied immediately and regardless of clk:
  - state=IDLE, anim_reset=1, serve=0
  - p1_score=0, p2_score=0, countdown=0
  - game_over=0, winner=0
  - synchroniser flops cleared, tick counter cleared
- Reset deasserting in the middle of a match always restarts in IDLE.
- All outputs are registered.
- start_btn path:
  - two-flop synchroniser, then a rising-edge detector; start_evt is a one-cycle pulse.
  - A held button produces exactly one start_evt.
- Score inputs:
  - sampled directly; they are synchronous to clk.
  - A score input held high produces one event only (rising-edge detection).
- State encoding for state_o: IDLE=0, COUNTDOWN=1, PLAY=2, GAME_OVER=3.
- IDLE:
  - anim_reset=1.
  - start_evt -> clear both scores, load countdown=SERVE_DELAY, clear tick counter, go to COUNTDOWN.
- COUNTDOWN:
  - anim_reset=0.
  - Tick counter runs 0..TICK_CYCLES-1.
  - At TICK_CYCLES-1: counter wraps to 0 and countdown decrements.
  - When countdown=1 and the counter reaches TICK_CYCLES-1: countdown becomes 0, go to PLAY, and serve=1 in the first PLAY cycle only.
  - COUNTDOWN therefore lasts exactly SERVE_DELAY*TICK_CYCLES cycles.
  - Score pulses and start_evt are ignored in this state.
- PLAY:
  - anim_reset=0, serve=0 after its single cycle.
  - A score1 rising edge increments p1_score. A score2 rising edge increments p2_score.
  - If both edges arrive in the same cycle, player 1 takes priority and the score2 event is dropped.
  - If the incremented score equals WIN_SCORE: go to GAME_OVER, game_over=1, winner=scoring player.
  - Otherwise: reload countdown=SERVE_DELAY, clear the tick counter, go to COUNTDOWN. Scores hold.
  - start_evt is ignored in this state.
- GAME_OVER:
  - anim_reset=1, game_over=1; scores and winner are frozen.
  - start_evt -> clear scores, game_over=0, winner=0, countdown=SERVE_DELAY, go to COUNTDOWN.
- Arithmetic:
  - Scores are 4-bit unsigned and never exceed WIN_SCORE, so they cannot wrap.
  - Tick counter is 32-bit unsigned.
- Latency:
  - start_btn rise to start_evt: 3 cycles.
  - start_evt to COUNTDOWN: 1 cycle.
  - score pulse to score output update: 1 cycle.
- Score outputs must update in the same cycle the state leaves PLAY.

Test Plan:
- Bench parameters: TICK_CYCLES=4, SERVE_DELAY=3, WIN_SCORE=3.
- Reset: hold reset=0 with toggling inputs -> anim_reset=1, serve=0, scores=0, state_o=0. Release -> stays in IDLE.
- Start and serve: pulse start_btn -> state_o=1 with countdown=3, then 2 and 1, each lasting 4 cycles. serve high exactly one cycle, 12 cycles after COUNTDOWN entry, in which state_o=2 and countdown=0.
- Scoring: in PLAY pulse score2 -> p2_score=1, state_o=1, countdown=3. After the next serve, pulse score1 -> p1_score=1. Hold score1 high for 5 cycles -> p1_score increments by 1 only.
- Win: drive p1 to 3 -> game_over=1, winner=0, anim_reset=1, state_o=3. Further score pulses -> scores frozen. Start -> scores=0, state_o=1.
- Simultaneous and ignored events:
  - score1 and score2 in the same PLAY cycle -> p1 +1 only.
  - Score pulses during COUNTDOWN -> no change.
  - start_btn during PLAY -> no change.
- Mid-operation reset: assert reset mid-COUNTDOWN with p2_score=2 -> immediate IDLE, scores 0, anim_reset=1, no serve pulse.

Source files
------------

// File: rtl/match_ctrl.sv
// Match-level sequencer for the pong datapath: sequences start, countdown,
// serve, scoring and win detection, and holds the animation block in reset.
module match_ctrl #(
    parameter int unsigned TICK_CYCLES = 100000000,
    parameter int unsigned SERVE_DELAY = 3,
    parameter int unsigned WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       score1,
    input  logic       score2,
    output logic       anim_reset,
    output logic       serve,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [3:0] countdown,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        GAME_OVER = 3'd3
    } state_t;

    localparam logic [31:0] TICK_LAST  = 32'(TICK_CYCLES - 1);
    localparam logic [3:0]  DELAY_INIT = 4'(SERVE_DELAY);
    localparam logic [3:0]  WIN_VAL    = 4'(WIN_SCORE);

    state_t      state_reg, state_next;
    logic        sync1_reg, sync2_reg, sync3_reg, start_evt_reg;
    logic        score1_prev_reg, score2_prev_reg;
    logic [31:0] tick_reg, tick_next;
    logic [3:0]  p1_reg, p1_next, p2_reg, p2_next;
    logic [3:0]  countdown_reg, countdown_next;
    logic        serve_reg, serve_next;
    logic        game_over_reg, game_over_next;
    logic        winner_reg, winner_next;
    logic        anim_reset_reg, anim_reset_next;
    logic        s1_evt, s2_evt;

    // Score inputs are already synchronous; only edge detection is needed.
    assign s1_evt = score1 & ~score1_prev_reg;
    assign s2_evt = score2 & ~score2_prev_reg;

    always_comb begin
        state_next     = state_reg;
        tick_next      = tick_reg;
        p1_next        = p1_reg;
        p2_next        = p2_reg;
        countdown_next = countdown_reg;
        serve_next     = 1'b0;
        game_over_next = game_over_reg;
        winner_next    = winner_reg;
        case (state_reg)
            IDLE, GAME_OVER: begin
                if (start_evt_reg) begin
                    p1_next        = 4'd0;
                    p2_next        = 4'd0;
                    game_over_next = 1'b0;
                    winner_next    = 1'b0;
                    countdown_next = DELAY_INIT;
                    tick_next      = 32'd0;
                    state_next     = COUNTDOWN;
                end
            end
            COUNTDOWN: begin
                if (tick_reg == TICK_LAST) begin
                    tick_next = 32'd0;
                    if (countdown_reg == 4'd1) begin
                        countdown_next = 4'd0;
                        serve_next     = 1'b1;
                        state_next     = PLAY;
                    end else begin
                        countdown_next = countdown_reg - 4'd1;
                    end
                end else begin
                    tick_next = tick_reg + 32'd1;
                end
            end
            PLAY: begin
                // Player 1 wins a same-cycle tie; the score2 edge is dropped.
                if (s1_evt || s2_evt) begin
                    if (s1_evt) begin
                        p1_next     = p1_reg + 4'd1;
                        winner_next = 1'b0;
                    end else begin
                        p2_next     = p2_reg + 4'd1;
                        winner_next = 1'b1;
                    end
                    if ((s1_evt && (p1_reg + 4'd1) == WIN_VAL) ||
                        (!s1_evt && (p2_reg + 4'd1) == WIN_VAL)) begin
                        game_over_next = 1'b1;
                        state_next     = GAME_OVER;
                    end else begin
                        winner_next    = winner_reg;
                        countdown_next = DELAY_INIT;
                        tick_next      = 32'd0;
                        state_next     = COUNTDOWN;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        anim_reset_next = (state_next == IDLE) || (state_next == GAME_OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            sync1_reg       <= 1'b0;
            sync2_reg       <= 1'b0;
            sync3_reg       <= 1'b0;
            start_evt_reg   <= 1'b0;
            score1_prev_reg <= 1'b0;
            score2_prev_reg <= 1'b0;
            tick_reg        <= 32'd0;
            p1_reg          <= 4'd0;
            p2_reg          <= 4'd0;
            countdown_reg   <= 4'd0;
            serve_reg       <= 1'b0;
            game_over_reg   <= 1'b0;
            winner_reg      <= 1'b0;
            anim_reset_reg  <= 1'b1;
        end else begin
            state_reg       <= state_next;
            sync1_reg       <= start_btn;
            sync2_reg       <= sync1_reg;
            sync3_reg       <= sync2_reg;
            start_evt_reg   <= sync2_reg & ~sync3_reg;
            score1_prev_reg <= score1;
            score2_prev_reg <= score2;
            tick_reg        <= tick_next;
            p1_reg          <= p1_next;
            p2_reg          <= p2_next;
            countdown_reg   <= countdown_next;
            serve_reg       <= serve_next;
            game_over_reg   <= game_over_next;
            winner_reg      <= winner_next;
            anim_reset_reg  <= anim_reset_next;
        end
    end

    assign anim_reset = anim_reset_reg;
    assign serve      = serve_reg;
    assign p1_score   = p1_reg;
    assign p2_score   = p2_reg;
    assign countdown  = countdown_reg;
    assign game_over  = game_over_reg;
    assign winner     = winner_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: directed match flow with randomized
// noise and rallies, checked against a score/timing model kept here.
module tb_match_ctrl;

    localparam int TICK  = 4;
    localparam int DELAY = 3;
    localparam int WIN   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       score1;
    logic       score2;
    logic       anim_reset;
    logic       serve;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] countdown;
    logic       game_over;
    logic       winner;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    int exp_p1 = 0;
    int exp_p2 = 0;
    bit exp_over = 1'b0;
    bit exp_winner = 1'b0;

    match_ctrl #(
        .TICK_CYCLES(TICK),
        .SERVE_DELAY(DELAY),
        .WIN_SCORE(WIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_btn(start_btn),
        .score1(score1),
        .score2(score2),
        .anim_reset(anim_reset),
        .serve(serve),
        .p1_score(p1_score),
        .p2_score(p2_score),
        .countdown(countdown),
        .game_over(game_over),
        .winner(winner),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Current negedge is the first COUNTDOWN cycle; runs through the serve.
    task automatic run_countdown(input bit noise, input bit hold1);
        for (int i = 0; i < DELAY * TICK; i++) begin
            chk("cd_state", 32'(state_o), 32'd1);
            chk("cd_value", 32'(countdown), 32'(DELAY - i / TICK));
            chk("cd_serve", 32'(serve), 32'd0);
            chk("cd_anim", 32'(anim_reset), 32'd0);
            chk("cd_p1", 32'(p1_score), 32'(exp_p1));
            chk("cd_p2", 32'(p2_score), 32'(exp_p2));
            score1 = hold1 ? 1'b1 : (noise && ($urandom_range(0, 3) == 0));
            score2 = noise && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        chk("serve_state", 32'(state_o), 32'd2);
        chk("serve_pulse", 32'(serve), 32'd1);
        chk("serve_cd", 32'(countdown), 32'd0);
        chk("serve_p1", 32'(p1_score), 32'(exp_p1));
        chk("serve_p2", 32'(p2_score), 32'(exp_p2));
        if (!hold1) score1 = 1'b0;
        score2 = 1'b0;
        @(negedge clk);
        chk("serve_once", 32'(serve), 32'd0);
        chk("play_state", 32'(state_o), 32'd2);
        chk("play_p1", 32'(p1_score), 32'(exp_p1));
    endtask

    task automatic start_match();
        int n = 0;
        start_btn = 1'b1;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (state_o == 3'd1) break;
        end
        chk("start_latency", 32'(n), 32'd4);
        start_btn = 1'b0;
        exp_p1 = 0;
        exp_p2 = 0;
        exp_over = 1'b0;
        exp_winner = 1'b0;
        chk("start_p1", 32'(p1_score), 32'd0);
        chk("start_p2", 32'(p2_score), 32'd0);
        chk("start_go", 32'(game_over), 32'd0);
        chk("start_win", 32'(winner), 32'd0);
    endtask

    // In PLAY: idle for gap cycles (inputs untouched), then strike once.
    task automatic do_score(input bit s1, input bit s2, input int gap, input bit press);
        bit won;
        for (int g = 0; g < gap; g++) begin
            if (press) start_btn = (g < 2);
            chk("gap_state", 32'(state_o), 32'd2);
            chk("gap_p1", 32'(p1_score), 32'(exp_p1));
            chk("gap_p2", 32'(p2_score), 32'(exp_p2));
            @(negedge clk);
        end
        start_btn = 1'b0;
        score1 = 1'b0;
        score2 = 1'b0;
        @(negedge clk);
        chk("pre_state", 32'(state_o), 32'd2);
        score1 = s1;
        score2 = s2;
        @(negedge clk);
        score1 = 1'b0;
        score2 = 1'b0;
        if (s1) begin
            exp_p1++;
            exp_winner = 1'b0;
            won = (exp_p1 == WIN);
        end else begin
            exp_p2++;
            exp_winner = 1'b1;
            won = (exp_p2 == WIN);
        end
        exp_over = won;
        chk("hit_p1", 32'(p1_score), 32'(exp_p1));
        chk("hit_p2", 32'(p2_score), 32'(exp_p2));
        chk("hit_state", 32'(state_o), won ? 32'd3 : 32'd1);
        chk("hit_cd", 32'(countdown), won ? 32'd0 : 32'(DELAY));
        chk("hit_go", 32'(game_over), 32'(won));
        chk("hit_win", 32'(winner), won ? 32'(exp_winner) : 32'd0);
        chk("hit_anim", 32'(anim_reset), 32'(won));
        chk("hit_serve", 32'(serve), 32'd0);
    endtask

    initial begin
        int guard;
        bit s1;
        bit s2;
        reset = 1'b1;
        start_btn = 1'b0;
        score1 = 1'b0;
        score2 = 1'b0;
        #3 reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_btn = 1'($urandom_range(0, 1));
            score1 = 1'($urandom_range(0, 1));
            score2 = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_anim", 32'(anim_reset), 32'd1);
            chk("rst_serve", 32'(serve), 32'd0);
            chk("rst_scores", 32'({p1_score, p2_score}), 32'd0);
            chk("rst_state", 32'(state_o), 32'd0);
            chk("rst_cd", 32'(countdown), 32'd0);
        end
        start_btn = 1'b0;
        score1 = 1'b0;
        score2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_state", 32'(state_o), 32'd0);
            chk("idle_anim", 32'(anim_reset), 32'd1);
        end

        start_match();
        run_countdown(1'b1, 1'b0);
        do_score(1'b0, 1'b1, 1, 1'b0);
        run_countdown(1'b1, 1'b1);
        do_score(1'b1, 1'b0, 3, 1'b0);
        run_countdown(1'b1, 1'b0);
        do_score(1'b1, 1'b1, 8, 1'b1);
        run_countdown(1'b1, 1'b0);
        do_score(1'b1, 1'b0, 2, 1'b0);

        for (int i = 0; i < 10; i++) begin
            score1 = 1'($urandom_range(0, 1));
            score2 = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("go_state", 32'(state_o), 32'd3);
            chk("go_p1", 32'(p1_score), 32'(exp_p1));
            chk("go_p2", 32'(p2_score), 32'(exp_p2));
            chk("go_flag", 32'(game_over), 32'd1);
            chk("go_winner", 32'(winner), 32'(exp_winner));
            chk("go_anim", 32'(anim_reset), 32'd1);
        end
        score1 = 1'b0;
        score2 = 1'b0;
        @(negedge clk);

        start_match();
        chk("restart_anim", 32'(anim_reset), 32'd0);
        run_countdown(1'b1, 1'b0);
        guard = 0;
        while (!exp_over && guard < 20) begin
            s1 = 1'($urandom_range(0, 1));
            s2 = s1 ? 1'($urandom_range(0, 1)) : 1'b1;
            do_score(s1, s2, int'($urandom_range(0, 4)), 1'b0);
            if (!exp_over) run_countdown(1'b1, 1'b0);
            guard++;
        end
        chk("rand_over", 32'(exp_over), 32'd1);
        @(negedge clk);

        start_match();
        run_countdown(1'b1, 1'b0);
        do_score(1'b0, 1'b1, 1, 1'b0);
        run_countdown(1'b1, 1'b0);
        do_score(1'b0, 1'b1, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("mid_p2", 32'(p2_score), 32'd2);
        reset = 1'b0;
        #1;
        exp_p1 = 0;
        exp_p2 = 0;
        chk("mid_state", 32'(state_o), 32'd0);
        chk("mid_scores", 32'({p1_score, p2_score}), 32'd0);
        chk("mid_anim", 32'(anim_reset), 32'd1);
        chk("mid_cd", 32'(countdown), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("post_state", 32'(state_o), 32'd0);
            chk("post_serve", 32'(serve), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
